// File: rtl/dnn_batch_seq_pkg.sv
// rtl/dnn_batch_seq_pkg.sv - engine mode type shared by the batch sequencer and its users
package dnn_batch_seq_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAYER1    = 2'd1,
    FINAL_OUT = 2'd2
  } dnn_state_t;
endpackage

// File: rtl/dnn_batch_seq.sv
// rtl/dnn_batch_seq.sv - pairs input vectors into a two-sample batch, drives layer-1 per sample,
// aggregates hidden activations and returns the engine's final outputs over valid/ready
module dnn_batch_seq
  import dnn_batch_seq_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TCNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic signed [6:0]  s_x0,
  input  logic signed [6:0]  s_x1,
  input  logic signed [6:0]  s_x2,
  input  logic signed [6:0]  s_x3,
  output logic signed [6:0]  x0,
  output logic signed [6:0]  x1,
  output logic signed [6:0]  x2,
  output logic signed [6:0]  x3,
  output logic               in_ready,
  output dnn_state_t         dnn_state,
  input  logic signed [12:0] y4_relu,
  input  logic signed [12:0] y5_relu,
  input  logic signed [12:0] y6_relu,
  input  logic signed [12:0] y7_relu,
  output logic signed [14:0] y4_n0_aggr,
  output logic signed [14:0] y5_n0_aggr,
  output logic signed [14:0] y6_n0_aggr,
  output logic signed [14:0] y7_n0_aggr,
  output logic signed [14:0] y4_n1_aggr,
  output logic signed [14:0] y5_n1_aggr,
  output logic signed [14:0] y6_n1_aggr,
  output logic signed [14:0] y7_n1_aggr,
  input  logic signed [20:0] out0_n0,
  input  logic signed [20:0] out1_n0,
  input  logic signed [20:0] out0_n1,
  input  logic signed [20:0] out1_n1,
  input  logic               out0_n0_ready,
  output logic               m_valid,
  input  logic               m_ready,
  output logic signed [20:0] m_out0_s0,
  output logic signed [20:0] m_out1_s0,
  output logic signed [20:0] m_out0_s1,
  output logic signed [20:0] m_out1_s1,
  output logic               m_single,
  output logic               err
);

  typedef enum logic [3:0] {
    S_IDLE, S_L1_S0, S_CAP_S0, S_WAIT_S1, S_L1_S1, S_CAP_S1, S_FINAL, S_OUT_WAIT, S_RESULT
  } state_t;

  localparam logic [TCNT_W-1:0] TC_LAST = TCNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t             state_q, state_d;
  logic signed [6:0]  x_q [4];
  logic signed [14:0] n0_q [4];
  logic signed [14:0] n1_q [4];
  logic [TCNT_W-1:0]  tcnt_q;
  logic               single_q, m_valid_q, m_single_q, err_q;
  logic signed [20:0] m_out_q [4];

  logic load_x, clr_n1, cap_n0, cap_n1, clr_cnt, inc_cnt, set_single, cap_out, done;

  always_comb begin
    state_d    = state_q;
    s_ready    = 1'b0;
    in_ready   = 1'b0;
    dnn_state  = IDLE;
    load_x     = 1'b0;
    clr_n1     = 1'b0;
    cap_n0     = 1'b0;
    cap_n1     = 1'b0;
    clr_cnt    = 1'b0;
    inc_cnt    = 1'b0;
    set_single = 1'b0;
    cap_out    = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          load_x  = 1'b1;
          clr_n1  = 1'b1;
          state_d = S_L1_S0;
        end
      end
      S_L1_S0: begin
        in_ready  = 1'b1;
        dnn_state = LAYER1;
        state_d   = S_CAP_S0;
      end
      S_CAP_S0: begin
        in_ready  = 1'b1;
        dnn_state = LAYER1;
        cap_n0    = 1'b1;
        clr_cnt   = 1'b1;
        state_d   = S_WAIT_S1;
      end
      S_WAIT_S1: begin
        s_ready = 1'b1;
        // A sample arriving on the expiry cycle still wins over the timeout.
        if (s_valid) begin
          load_x  = 1'b1;
          state_d = S_L1_S1;
        end else if (TIMEOUT != 0) begin
          inc_cnt = 1'b1;
          if (tcnt_q == TC_LAST) begin
            set_single = 1'b1;
            state_d    = S_FINAL;
          end
        end
      end
      S_L1_S1: begin
        in_ready  = 1'b1;
        dnn_state = LAYER1;
        state_d   = S_CAP_S1;
      end
      S_CAP_S1: begin
        in_ready  = 1'b1;
        dnn_state = LAYER1;
        cap_n1    = 1'b1;
        state_d   = S_FINAL;
      end
      S_FINAL: begin
        dnn_state = FINAL_OUT;
        state_d   = S_OUT_WAIT;
      end
      S_OUT_WAIT: begin
        cap_out = 1'b1;
        state_d = S_RESULT;
      end
      S_RESULT: begin
        if (m_ready) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        x_q[i]     <= '0;
        n0_q[i]    <= '0;
        n1_q[i]    <= '0;
        m_out_q[i] <= '0;
      end
      tcnt_q     <= '0;
      single_q   <= 1'b0;
      m_valid_q  <= 1'b0;
      m_single_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (load_x) begin
        x_q[0] <= s_x0;
        x_q[1] <= s_x1;
        x_q[2] <= s_x2;
        x_q[3] <= s_x3;
      end
      if (cap_n0) begin
        n0_q[0] <= {2'b00, y4_relu};
        n0_q[1] <= {2'b00, y5_relu};
        n0_q[2] <= {2'b00, y6_relu};
        n0_q[3] <= {2'b00, y7_relu};
      end
      // Cleared on batch start so a timed-out batch reports zero sample-1 activations.
      if (clr_n1) begin
        for (int i = 0; i < 4; i++) n1_q[i] <= '0;
      end else if (cap_n1) begin
        n1_q[0] <= {2'b00, y4_relu};
        n1_q[1] <= {2'b00, y5_relu};
        n1_q[2] <= {2'b00, y6_relu};
        n1_q[3] <= {2'b00, y7_relu};
      end
      if (clr_cnt)      tcnt_q <= '0;
      else if (inc_cnt) tcnt_q <= tcnt_q + TCNT_W'(1);
      if (set_single)   single_q <= 1'b1;
      else if (done)    single_q <= 1'b0;
      if (cap_out) begin
        m_out_q[0] <= out0_n0;
        m_out_q[1] <= out1_n0;
        m_out_q[2] <= out0_n1;
        m_out_q[3] <= out1_n1;
        m_valid_q  <= 1'b1;
        m_single_q <= single_q;
        if (!out0_n0_ready) err_q <= 1'b1;
      end else if (done) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign x0 = x_q[0];
  assign x1 = x_q[1];
  assign x2 = x_q[2];
  assign x3 = x_q[3];
  assign y4_n0_aggr = n0_q[0];
  assign y5_n0_aggr = n0_q[1];
  assign y6_n0_aggr = n0_q[2];
  assign y7_n0_aggr = n0_q[3];
  assign y4_n1_aggr = n1_q[0];
  assign y5_n1_aggr = n1_q[1];
  assign y6_n1_aggr = n1_q[2];
  assign y7_n1_aggr = n1_q[3];
  assign m_out0_s0  = m_out_q[0];
  assign m_out1_s0  = m_out_q[1];
  assign m_out0_s1  = m_out_q[2];
  assign m_out1_s1  = m_out_q[3];
  assign m_valid    = m_valid_q;
  assign m_single   = m_single_q;
  assign err        = err_q;

endmodule
